// File: rtl/act_skew_ctrl.sv
// Read-side sequencer for the activation FIFO bank: staggered per-row read enables,
// per-row valids and ping-pong buffer select. Optional lane zero-masking: ACT_SKEW_ZERO_MASK_EN.
module act_skew_ctrl #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int ROW           = 8,
  parameter int LEN_WIDTH     = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         len,
  input  logic                         hold,
  input  logic                         fifo_empty,
  input  logic [IN_DATA_WIDTH*ROW-1:0] fifo_dout,
  output logic [ROW-1:0]               read_en,
  output logic                         sel,
  output logic [IN_DATA_WIDTH*ROW-1:0] act_out,
  output logic [ROW-1:0]               row_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int T_W = $clog2(2 * ROW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [T_W-1:0]       t_q, t_d, t_inc;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [ROW-1:0]       en_mask_q, en_mask_d;
  logic [ROW-1:0]       row_valid_q;
  logic                 sel_q, sel_d;
  logic                 last_step;

  // Lane i reads while the step counter lies in the window [i, i+n).
  function automatic logic [ROW-1:0] lane_mask(input logic [T_W-1:0] t,
                                               input logic [LEN_WIDTH-1:0] n);
    logic [ROW-1:0] m;
    m = '0;
    for (int i = 0; i < ROW; i++) begin
      m[i] = (int'(t) >= i) && (int'(t) < i + int'(n));
    end
    return m;
  endfunction

  assign t_inc     = t_q + T_W'(1);
  assign last_step = (int'(t_q) == int'(len_q) + ROW - 2);

  // The mask for the next step is precomputed into a register; hold only gates it.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d   = state_q;
    t_d       = t_q;
    len_d     = len_q;
    sel_d     = sel_q;
    en_mask_d = '0;
    case (state_q)
      IDLE: begin
        if (start && (len != '0) && !fifo_empty) begin
          state_d   = RUN;
          t_d       = '0;
          len_d     = len;
          en_mask_d = lane_mask(T_W'(0), len);
        end
      end
      RUN: begin
        if (hold) begin
          en_mask_d = en_mask_q;
        end else if (last_step) begin
          state_d = DRAIN;
        end else begin
          t_d       = t_inc;
          en_mask_d = lane_mask(t_inc, len_q);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        sel_d   = ~sel_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign read_en = en_mask_q & {ROW{~hold}};

  // NOTE: state registers use non-blocking assignments so all flops update together.
  // NOTE: every register, including the read-window mask, is cleared by the async reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      t_q         <= '0;
      len_q       <= '0;
      en_mask_q   <= '0;
      row_valid_q <= '0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      len_q       <= len_d;
      en_mask_q   <= en_mask_d;
      row_valid_q <= read_en;
      sel_q       <= sel_d;
    end
  end

  assign row_valid = row_valid_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DRAIN);

`ifdef ACT_SKEW_ZERO_MASK_EN
  // Registered valid aligns with the FIFO's one-cycle read latency, so no extra delay.
  for (genvar g = 0; g < ROW; g++) begin : g_mask
    assign act_out[IN_DATA_WIDTH*g +: IN_DATA_WIDTH] =
      row_valid_q[g] ? fifo_dout[IN_DATA_WIDTH*g +: IN_DATA_WIDTH] : '0;
  end
`else
  assign act_out = fifo_dout;
`endif

endmodule

// File: tb/tb_act_skew_ctrl.sv
// Self-checking bench for act_skew_ctrl: FIFO bank stub, schedule-level reference model,
// directed scenarios from the test plan and randomized tiles with random holds.
module tb_act_skew_ctrl;

  localparam int W    = 8;
  localparam int R    = 8;
  localparam int LW   = 4;
  localparam int MAXC = 48;

  logic           clk;
  logic           rstn;
  logic           start;
  logic [LW-1:0]  len;
  logic           hold;
  logic           fifo_empty;
  logic [W*R-1:0] fifo_dout;
  logic [R-1:0]   read_en;
  logic           sel;
  logic [W*R-1:0] act_out;
  logic [R-1:0]   row_valid;
  logic           busy;
  logic           done;

  act_skew_ctrl #(.IN_DATA_WIDTH(W), .ROW(R), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .len        (len),
    .hold       (hold),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .read_en    (read_en),
    .sel        (sel),
    .act_out    (act_out),
    .row_valid  (row_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO bank stub: one-cycle read latency, output holds between reads.
  logic [W-1:0] mem [R][R];
  logic [3:0]   rd  [R];
  logic [W-1:0] dq  [R];
  logic         stub_clr;
  logic [W-1:0] fill;

  always @(posedge clk) begin
    for (int i = 0; i < R; i++) begin
      if (stub_clr) begin
        rd[i] <= '0;
        dq[i] <= fill;
      end else if (read_en[i]) begin
        dq[i] <= mem[i][rd[i][2:0]];
        rd[i] <= rd[i] + 4'd1;
      end
    end
  end

  always_comb begin
    fifo_dout = '0;
    for (int i = 0; i < R; i++) fifo_dout[i*W +: W] = dq[i];
  end

  int errors = 0;
  int checks = 0;
  logic sel_exp;

  // Expected schedule and observed history of the current tile.
  logic [R-1:0] e_re [MAXC];
  logic [R-1:0] e_rv [MAXC];
  logic         e_busy [MAXC];
  logic         e_done [MAXC];
  logic [R-1:0] h_re [MAXC];
  logic         h_busy [MAXC];
  logic         h_done [MAXC];
  logic         h_sel [MAXC];
  logic [W-1:0] h_act [MAXC][R];

  // Tile schedule from the stagger rules: each non-hold RUN cycle advances one step;
  // the drain cycle follows the step len+ROW-2.
  task automatic build_schedule(input int L, input logic [63:0] hmask, output int dc);
    int c;
    int s;
    for (int k = 0; k < MAXC; k++) begin
      e_re[k] = '0; e_rv[k] = '0; e_busy[k] = 1'b0; e_done[k] = 1'b0;
    end
    c = 1;
    s = 0;
    while (s <= L + R - 2 && c < MAXC - 3) begin
      e_busy[c] = 1'b1;
      if (!hmask[c]) begin
        for (int i = 0; i < R; i++) e_re[c][i] = (s >= i) && (s < i + L);
        s++;
      end
      c++;
    end
    dc = c;
    e_busy[dc] = 1'b1;
    e_done[dc] = 1'b1;
    for (int k = 1; k < MAXC; k++) e_rv[k] = e_re[k-1];
  endtask

  task automatic prep_tile(input int L, input logic [W-1:0] f, input logic rnd);
    fill = f;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++)
        mem[i][j] = rnd ? W'($urandom) : f;
    stub_clr = 1'b1;
    @(posedge clk); #1;
    stub_clr = 1'b0;
  endtask

  // Runs one tile starting in cycle 0; checks every cycle against the schedule.
  task automatic run_tile(input int L, input logic [63:0] hmask, input int xstart,
                          input int abort_at, output int dc);
    int last_c;
    int k[R];
    int reads[R];
    logic sel0;
    logic [W-1:0] ea;
    build_schedule(L, hmask, dc);
    sel0 = sel_exp;
    last_c = (abort_at >= 0) ? abort_at - 1 : dc + 2;
    for (int i = 0; i < R; i++) begin k[i] = 0; reads[i] = 0; end
    for (int c = 0; c < MAXC; c++) begin
      h_re[c] = '0; h_busy[c] = 1'b0; h_done[c] = 1'b0; h_sel[c] = 1'b0;
      for (int i = 0; i < R; i++) h_act[c][i] = '0;
    end
    for (int c = 0; c <= last_c; c++) begin
      start      = (c == 0) || (c == xstart);
      len        = (c == 0 || c == xstart) ? LW'(L) : LW'($urandom_range(0, 15));
      fifo_empty = (c == 0 || c == xstart) ? 1'b0 : 1'($urandom_range(0, 1));
      hold       = hmask[c];
      @(negedge clk);
      h_re[c] = read_en; h_busy[c] = busy; h_done[c] = done; h_sel[c] = sel;
      for (int i = 0; i < R; i++) h_act[c][i] = act_out[i*W +: W];
      checks++;
      if (read_en !== e_re[c]) begin
        errors++; $display("FAIL read_en c=%0d got=%b exp=%b", c, read_en, e_re[c]);
      end
      checks++;
      if (row_valid !== e_rv[c]) begin
        errors++; $display("FAIL row_valid c=%0d got=%b exp=%b", c, row_valid, e_rv[c]);
      end
      checks++;
      if (busy !== e_busy[c]) begin
        errors++; $display("FAIL busy c=%0d got=%b exp=%b", c, busy, e_busy[c]);
      end
      checks++;
      if (done !== e_done[c]) begin
        errors++; $display("FAIL done c=%0d got=%b exp=%b", c, done, e_done[c]);
      end
      checks++;
      if (sel !== ((c > dc) ? ~sel0 : sel0)) begin
        errors++; $display("FAIL sel c=%0d got=%b exp=%b", c, sel, (c > dc) ? ~sel0 : sel0);
      end
      for (int i = 0; i < R; i++) begin
        if (read_en[i] === 1'b1) reads[i]++;
        if (e_rv[c][i]) begin
          ea = mem[i][k[i] % R];
          k[i]++;
        end else begin
`ifdef ACT_SKEW_ZERO_MASK_EN
          ea = '0;
`else
          ea = dq[i];
`endif
        end
        checks++;
        if (act_out[i*W +: W] !== ea) begin
          errors++;
          $display("FAIL act_out c=%0d lane=%0d got=%h exp=%h", c, i, act_out[i*W +: W], ea);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    hold  = 1'b0;
    if (abort_at < 0) begin
      sel_exp = ~sel0;
      for (int i = 0; i < R; i++) begin
        checks++;
        if (reads[i] != L) begin
          errors++; $display("FAIL read_count lane=%0d got=%0d exp=%0d", i, reads[i], L);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; len = '0; hold = 1'b0; fifo_empty = 1'b1;
    stub_clr = 1'b1; fill = '0;
    sel_exp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({read_en, row_valid, busy, done, sel} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {read_en, row_valid, busy, done, sel});
    end
    checks++;
    if (act_out !== '0) begin
      errors++; $display("FAIL reset_act_out got=%h exp=0", act_out);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    stub_clr = 1'b0;
  endtask

  // Shared literal checks of the full-length, no-hold tile.
  task automatic check_full_literals(input int dc, input string tag);
    logic [W-1:0] e7;
    checks++;
    if (dc != 16) begin errors++; $display("FAIL %s done_cycle got=%0d exp=16", tag, dc); end
    for (int c = 0; c <= 17; c++) begin
      checks++;
      if (h_re[c][0] !== (c >= 1 && c <= 8)) begin
        errors++; $display("FAIL %s re0 c=%0d got=%b", tag, c, h_re[c][0]);
      end
      checks++;
      if (h_re[c][7] !== (c >= 8 && c <= 15)) begin
        errors++; $display("FAIL %s re7 c=%0d got=%b", tag, c, h_re[c][7]);
      end
      checks++;
      if (h_done[c] !== (c == 16) || h_busy[c] !== (c >= 1 && c <= 16)) begin
        errors++; $display("FAIL %s done_busy c=%0d got=%b%b", tag, c, h_done[c], h_busy[c]);
      end
`ifdef ACT_SKEW_ZERO_MASK_EN
      e7 = (c >= 9 && c <= 16) ? 8'hFF : 8'h00;
`else
      e7 = 8'hFF;
`endif
      checks++;
      if (h_act[c][7] !== e7) begin
        errors++; $display("FAIL %s lane7 c=%0d got=%h exp=%h", tag, c, h_act[c][7], e7);
      end
    end
    checks++;
    if (h_sel[17] !== 1'b1) begin errors++; $display("FAIL %s sel17 got=%b exp=1", tag, h_sel[17]); end
  endtask

  task automatic test_full_tile();
    int dc;
    prep_tile(8, 8'hFF, 1'b0);
    run_tile(8, 64'd0, -1, -1, dc);
    check_full_literals(dc, "full");
  endtask

  task automatic test_short_tile();
    int dc;
    prep_tile(3, 8'h00, 1'b1);
    mem[5][0] = 8'h11; mem[5][1] = 8'h22; mem[5][2] = 8'h33;
    run_tile(3, 64'd0, -1, -1, dc);
    for (int c = 7; c <= 11; c++) begin
      checks++;
      if (h_re[c][7] !== (c >= 8 && c <= 10)) begin
        errors++; $display("FAIL short_re7 c=%0d got=%b", c, h_re[c][7]);
      end
    end
    checks++;
    if (h_done[11] !== 1'b1 || dc != 11) begin
      errors++; $display("FAIL short_done got=%b dc=%0d exp=11", h_done[11], dc);
    end
    checks++;
    if ({h_act[7][5], h_act[8][5], h_act[9][5]} !== 24'h112233) begin
      errors++;
      $display("FAIL short_lane5 got=%h%h%h exp=112233", h_act[7][5], h_act[8][5], h_act[9][5]);
    end
  endtask

  task automatic test_hold();
    int dc;
    prep_tile(8, 8'h5A, 1'b1);
    run_tile(8, 64'h30, -1, -1, dc);
    checks++;
    if (h_re[4] !== '0 || h_re[5] !== '0) begin
      errors++; $display("FAIL hold_re got=%b/%b exp=0", h_re[4], h_re[5]);
    end
    checks++;
    if (dc != 18 || h_done[18] !== 1'b1 || h_done[16] !== 1'b0) begin
      errors++; $display("FAIL hold_done dc=%0d got=%b exp=18", dc, h_done[18]);
    end
  endtask

  task automatic test_rejected_start();
    prep_tile(4, 8'h00, 1'b1);
    for (int p = 0; p < 2; p++) begin
      start = 1'b1; hold = 1'b0;
      len = (p == 0) ? LW'(4) : LW'(0);
      fifo_empty = (p == 0) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      start = 1'b0; fifo_empty = 1'b0; len = LW'(5);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || read_en !== '0) begin
          errors++; $display("FAIL rejected_start p=%0d c=%0d got=%b%b exp=0", p, c, busy, read_en);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    int ndone;
    prep_tile(8, 8'h00, 1'b1);
    run_tile(8, 64'd0, 5, -1, dc);
    ndone = 0;
    for (int c = 0; c <= dc + 2; c++) if (h_done[c] === 1'b1) ndone++;
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL b2b_done_count got=%0d exp=1", ndone); end
    prep_tile(4, 8'h00, 1'b1);
    run_tile(4, 64'd0, 12, -1, dc);
    checks++;
    if (h_busy[13] !== 1'b0 || h_busy[14] !== 1'b0) begin
      errors++; $display("FAIL drain_start got=%b%b exp=00", h_busy[13], h_busy[14]);
    end
  endtask

  task automatic test_mid_reset();
    int dc;
    prep_tile(8, 8'h00, 1'b1);
    run_tile(8, 64'd0, -1, 6, dc);
    rstn = 1'b0;
    #1;
    checks++;
    if ({read_en, row_valid, busy, done, sel} !== '0) begin
      errors++;
      $display("FAIL mid_reset got=%b exp=0", {read_en, row_valid, busy, done, sel});
    end
    sel_exp = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    prep_tile(8, 8'hFF, 1'b0);
    run_tile(8, 64'd0, -1, -1, dc);
    check_full_literals(dc, "post_reset");
  endtask

  task automatic test_random();
    int dc;
    int L;
    logic [63:0] hm;
    for (int n = 0; n < 6; n++) begin
      L = $urandom_range(1, R);
      hm = '0;
      for (int c = 1; c < 26; c++) hm[c] = ($urandom_range(0, 3) == 0);
      prep_tile(L, W'($urandom), 1'b1);
      run_tile(L, hm, -1, -1, dc);
    end
  endtask

  initial begin
    test_reset();
    test_full_tile();
    test_short_tile();
    test_hold();
    test_rejected_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
